// File: rtl/hqm_aw_rf_pg_banked_pkg.sv
// ---------------------------------------------------------------------------
// hqm_AW_rf_pg_pkg
// Shared types and helpers for the power-gated banked register file.
//   pg_state_t      : power sequencer states
//   WAKE_CYCLES_MAX : largest supported per-bank wake delay
//   WAKE_CNT_W      : width of the wake counter (covers WAKE_CYCLES_MAX)
//   calc_aw/calc_bw : full address width and in-bank offset width
// ---------------------------------------------------------------------------
package hqm_AW_rf_pg_pkg;

  typedef enum logic [1:0] {
    PG_OFF  = 2'd0,
    PG_WAKE = 2'd1,
    PG_ON   = 2'd2
  } pg_state_t;

  localparam int WAKE_CYCLES_MAX = 15;
  localparam int WAKE_CNT_W      = 4;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_bw(input int depth, input int num_banks);
    return $clog2(depth) - $clog2(num_banks);
  endfunction

endpackage

// File: rtl/hqm_aw_rf_pg_banked_bank.sv
// ---------------------------------------------------------------------------
// hqm_AW_rf_pg_bank
// One behavioural bank of DEPTH x WIDTH with a registered read port.
//   rclk    : clock
//   en_i    : bank power enable; no access happens while low
//   we_i    : write strobe, waddr_i/wdata_i
//   re_i    : read strobe, raddr_i; dout_o updates on the next edge
//   dout_o  : registered read data, holds between reads
// Contents are not retained across a power cycle.
// ---------------------------------------------------------------------------
module hqm_AW_rf_pg_bank
  import hqm_AW_rf_pg_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 14,
  localparam int OW   = $clog2(DEPTH)
) (
  input  logic             rclk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [OW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [OW-1:0]    raddr_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  // Read returns the pre-write contents; the top level handles write-first.
  always_ff @(posedge rclk) begin
    if (en_i && we_i) mem_q[waddr_i] <= wdata_i;
    if (en_i && re_i) dout_q <= mem_q[raddr_i];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/hqm_aw_rf_pg_banked.sv
// ---------------------------------------------------------------------------
// hqm_aw_rf_pg_banked
// Power-gated, banked single-clock register file with a sequenced wake chain.
//   rclk, rclk_rst_n   : clock, async active-low reset
//   we/waddr/wdata     : write port (dropped while not fully powered)
//   re/raddr           : read port; rdata/rdata_v one cycle later
//   access_err         : pulse the cycle after any access made while unpowered
//   pgcb_isol_en       : forces rdata to zero
//   pwr_enable_b_in    : active-low power request
//   pwr_enable_b_out   : low only when all banks are on
//   pwr_ready          : all banks on
// ---------------------------------------------------------------------------
module hqm_aw_rf_pg_banked
  import hqm_AW_rf_pg_pkg::*;
#(
  parameter int DEPTH       = 2048,
  parameter int WIDTH       = 14,
  parameter int NUM_BANKS   = 2,
  parameter int WAKE_CYCLES = 4,
  localparam int AW         = calc_aw(DEPTH)
) (
  input  logic             rclk,
  input  logic             rclk_rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_v,
  output logic             access_err,
  input  logic             pgcb_isol_en,
  input  logic             pwr_enable_b_in,
  output logic             pwr_enable_b_out,
  output logic             pwr_ready
);

  localparam int BW     = calc_bw(DEPTH, NUM_BANKS);
  localparam int NB_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BDEPTH = DEPTH / NUM_BANKS;

  pg_state_t             state_q, state_d;
  logic [NB_W-1:0]       bank_idx_q, bank_idx_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [NUM_BANKS-1:0]  bank_en_q, bank_en_d;
  logic                  powered;

  logic [NB_W-1:0]       wbank, rbank;
  logic [BW-1:0]         woff, roff;

  logic                  rdata_v_q, access_err_q, rd_pwr_q;
  logic [NB_W-1:0]       rd_bank_q;
  logic                  rd_byp_q;
  logic [WIDTH-1:0]      rd_byp_data_q;
  logic [WIDTH-1:0]      bank_dout [NUM_BANKS];

  assign powered = (state_q == PG_ON);

  // Address split: upper bits pick the bank, lower bits the entry.
  if (NUM_BANKS > 1) begin : g_dec
    assign wbank = waddr[AW-1:BW];
    assign rbank = raddr[AW-1:BW];
  end else begin : g_nodec
    assign wbank = '0;
    assign rbank = '0;
  end
  assign woff = waddr[BW-1:0];
  assign roff = raddr[BW-1:0];

  // Wake sequencer: banks come up one at a time, WAKE_CYCLES apart.
  always_comb begin
    state_d    = state_q;
    bank_idx_d = bank_idx_q;
    wake_cnt_d = wake_cnt_q;
    bank_en_d  = bank_en_q;
    if (pwr_enable_b_in) begin
      state_d    = PG_OFF;
      bank_idx_d = '0;
      wake_cnt_d = '0;
      bank_en_d  = '0;
    end else begin
      case (state_q)
        PG_OFF: begin
          state_d    = PG_WAKE;
          bank_idx_d = '0;
          wake_cnt_d = '0;
        end
        PG_WAKE: begin
          if (wake_cnt_q == WAKE_CNT_W'(WAKE_CYCLES - 1)) begin
            bank_en_d[bank_idx_q] = 1'b1;
            wake_cnt_d            = '0;
            if (bank_idx_q == NB_W'(NUM_BANKS - 1)) state_d = PG_ON;
            else                                    bank_idx_d = bank_idx_q + 1'b1;
          end else begin
            wake_cnt_d = wake_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rclk_rst_n) begin
    if (!rclk_rst_n) begin
      state_q    <= PG_OFF;
      bank_idx_q <= '0;
      wake_cnt_q <= '0;
      bank_en_q  <= '0;
    end else begin
      state_q    <= state_d;
      bank_idx_q <= bank_idx_d;
      wake_cnt_q <= wake_cnt_d;
      bank_en_q  <= bank_en_d;
    end
  end

  // Read-side control. rd_pwr_q=0 makes the output read as zero, which covers
  // both reset and reads issued while unpowered.
  always_ff @(posedge rclk or negedge rclk_rst_n) begin
    if (!rclk_rst_n) begin
      rdata_v_q    <= 1'b0;
      access_err_q <= 1'b0;
      rd_pwr_q     <= 1'b0;
    end else begin
      rdata_v_q    <= re;
      access_err_q <= (re | we) & ~powered;
      if (re) rd_pwr_q <= powered;
    end
  end

  always_ff @(posedge rclk) begin
    if (re) begin
      rd_bank_q     <= rbank;
      rd_byp_q      <= we && (waddr == raddr);
      rd_byp_data_q <= wdata;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    hqm_AW_rf_pg_bank #(
      .DEPTH (BDEPTH),
      .WIDTH (WIDTH)
    ) u_bank (
      .rclk    (rclk),
      .en_i    (bank_en_q[b]),
      .we_i    (we && powered && (wbank == NB_W'(b))),
      .waddr_i (woff),
      .wdata_i (wdata),
      .re_i    (re && powered && (rbank == NB_W'(b))),
      .raddr_i (roff),
      .dout_o  (bank_dout[b])
    );
  end

  always_comb begin
    rdata = '0;
    if (!pgcb_isol_en && rd_pwr_q) rdata = rd_byp_q ? rd_byp_data_q : bank_dout[rd_bank_q];
  end

  assign rdata_v          = rdata_v_q;
  assign access_err       = access_err_q;
  assign pwr_ready        = powered;
  assign pwr_enable_b_out = ~powered;

endmodule

// File: doc/hqm_aw_rf_pg_banked.md
# hqm_AW_rf_pg_banked

Parametrised, power-gated, banked single-clock register file for HQM list and state storage. It splits DEPTH entries across NUM_BANKS equal banks selected by the upper address bits. Banks are powered up through a sequenced wake chain with a programmable per-bank delay, and the block reports when the whole array is ready. It adds a read-valid output, write-first bypass on same-address collision, and error flagging for accesses made while unpowered.

## Interface
- DEPTH, 2048, total entries; power of 2, ≥ NUM_BANKS*2
- WIDTH, 14, data bits per entry
- NUM_BANKS, 2, bank count; power of 2, 1..8
- WAKE_CYCLES, 4, cycles each bank waits before its enable asserts; 1..15
- rclk  in  1  clock; all logic on rising edge
- rclk_rst_n  in  1  reset rclk_rst_n, asynchronous, active-low; clock rclk
- we  in  1  write enable
- waddr  in  $clog2(DEPTH)  write address
- wdata  in  WIDTH  write data
- re  in  1  read enable
- raddr  in  $clog2(DEPTH)  read address
- rdata  out  WIDTH  read data; valid while rdata_v=1
- rdata_v  out  1  read-data valid, one cycle after re
- access_err  out  1  one-cycle pulse when re or we is seen while not powered
- pgcb_isol_en  in  1  isolation; forces rdata to 0
- pwr_enable_b_in  in  1  active-low power request
- pwr_enable_b_out  out  1  active-low chain output; 0 only when all banks are on
- pwr_ready  out  1  all banks powered; equals ~pwr_enable_b_out

## Operation
- AW = $clog2(DEPTH); BW = AW - $clog2(NUM_BANKS). Bank index = addr[AW-1:BW]; in-bank address = addr[BW-1:0]. With NUM_BANKS=1 there is no bank index.
- Power FSM states: PG_OFF, PG_WAKE, PG_ON. Reset state is PG_OFF.
  - PG_OFF: pwr_enable_b_in sampled 0 → PG_WAKE with bank_idx=0 and wake_cnt=0.
  - PG_WAKE: wake_cnt increments each cycle. When wake_cnt=WAKE_CYCLES-1, bank[bank_idx] is enabled, wake_cnt clears, and bank_idx increments. Enabling the last bank → PG_ON.
  - PG_ON: hold.
  - From any state, pwr_enable_b_in sampled 1 → PG_OFF next cycle. All bank enables clear simultaneously and bank_idx/wake_cnt clear.
- Contents of a bank are undefined after its enable drops; no retention.
- Write in PG_ON: mem[bank][off] ← wdata at the clock edge.
- Read in PG_ON: the target bank's entry is returned the next cycle with rdata_v=1.
- Collision: re and we to the same full address in the same cycle returns wdata (write-first). Different addresses are independent.
- Access in PG_OFF or PG_WAKE:
  - Write is dropped.
  - Read still produces rdata_v=1 with rdata=0.
  - access_err pulses the cycle after the access (one pulse even when re and we coincide).
- pgcb_isol_en=1: rdata is forced to 0 combinationally. rdata_v and memory updates are unaffected.

## Timing
- Reset values: rdata=0, rdata_v=0, access_err=0, pwr_enable_b_out=1, pwr_ready=0. All bank enables are 0.
- Read latency is 1 cycle. The bank-select and read-data registers update only when re=1. When re=0 the next cycle has rdata_v=0 and rdata holds its last value.
- Power-up: pwr_enable_b_in falls before edge N → PG_WAKE at N. pwr_ready rises at edge N + NUM_BANKS*WAKE_CYCLES. pwr_enable_b_out falls on the same edge.
- An access on the same edge that PG_ON is entered is still treated as unpowered.
- Power-down: pwr_enable_b_in rises before edge M → pwr_ready=0 and pwr_enable_b_out=1 at M. An access launched at M-1 completes normally.
- Async reset mid-wake or mid-read: all registers go to reset values immediately. A pending rdata_v is lost.

## Structure
- Package hqm_AW_rf_pg_pkg holds:
  - typedef enum logic [1:0] pg_state_t {PG_OFF, PG_WAKE, PG_ON}
  - localparam-style functions for AW and BW
  - the WAKE_CYCLES limit constant
- Sub-module hqm_AW_rf_pg_bank: one behavioural bank of DEPTH/NUM_BANKS × WIDTH with enable, we, re and in-bank addresses, and registered dout. It is instantiated NUM_BANKS times in a generate loop.
- The top level holds the FSM, bank decode, collision bypass, output mux and error logic.

## Test plan
- Default parameters, release reset, drive pwr_enable_b_in=0 at cycle 0 → pwr_ready=1 and pwr_enable_b_out=0 at cycle 8, not before.
- Powered. Write 0x1A5 to addr 0x005 and 0x2C3 to addr 0x405, then read both → rdata 0x1A5 then 0x2C3, each with rdata_v one cycle after re; this confirms bank decode.
- Powered. Same-cycle we and re to addr 0x3FF with wdata 0x3FFF → rdata=0x3FFF next cycle. A later read of 0x3FF also returns 0x3FFF.
- Read of 0x010 during PG_WAKE → rdata_v=1, rdata=0, access_err single pulse. A write during PG_OFF then a read after power-up → no write effect is observed (bank not written).
- Powered read with pgcb_isol_en=1 → rdata=0 and rdata_v=1. Deassert isolation with rdata_v held → stored value appears combinationally.
- NUM_BANKS=4, DEPTH=64, WAKE_CYCLES=3. Raise pwr_enable_b_in mid-wake at cycle 5 → PG_OFF next edge. Re-request → full 12-cycle wake. Assert async reset during a read → rdata_v=0 immediately.
